dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte/half/word data store behind a request/response handshake.
// Define DMEM_ACCESS_CNT_EN to add read/write/error access counters.
module dmem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  busy_o
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [31:0]           rd_count_o,
  output logic [31:0]           wr_count_o,
  output logic [31:0]           err_count_o
`endif
);

  localparam int IW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A =
    ADDR_WIDTH'(DEPTH_WORDS);
  localparam logic [1:0] LAST_CNT =
    2'(READ_LATENCY - 2);

  typedef enum logic {
    IDLE,
    READ
  } state_e;

  state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] raw_q, raw_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        rv_q, rv_d;
  logic        re_q, re_d;
  logic        rl_q, rl_d;

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] word_off;
  logic [IW-1:0]         idx;
  logic                  accept;
  logic                  size_bad;
  logic                  mis;
  logic                  range_bad;
  logic                  acc_err;
  logic                  good_rd;
  logic                  good_wr;
  logic                  bad;
  logic [3:0]            wmask;
  logic [31:0]           wdata;
  logic [31:0]           rd_word;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [31:0]           ext;

  logic [31:0] mem_q [DEPTH_WORDS];

  assign accept   = req_valid_i && (state_q == IDLE);
  assign off      = req_addr_i - BASE_ADDR;
  assign word_off = off >> 2;
  assign idx      = word_off[IW-1:0];

  // Alignment is checked on the raw address; BASE_ADDR is word aligned.
  always_comb begin
    size_bad = 1'b0;
    mis      = 1'b0;
    wmask    = 4'b0000;
    wdata    = req_wdata_i;
    unique case (req_size_i)
      2'b00: begin
        wmask = 4'b0001 << req_addr_i[1:0];
        wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        mis   = req_addr_i[0];
        wmask = req_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata = {2{req_wdata_i[15:0]}};
      end
      2'b10: begin
        mis   = |req_addr_i[1:0];
        wmask = 4'b1111;
      end
      default: begin
        size_bad = 1'b1;
      end
    endcase
  end

  assign range_bad = (req_addr_i < BASE_ADDR)
                  || (word_off >= DEPTH_A);
  assign acc_err = size_bad | mis | range_bad;
  assign good_rd = accept & ~acc_err & ~req_write_i;
  assign good_wr = accept & ~acc_err & req_write_i;
  assign bad     = accept & acc_err;

  // Store contents are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (good_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[k]) begin
          mem_q[idx][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

  assign rd_word = mem_q[idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raw_d   = raw_q;
    lane_d  = lane_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rv_d    = 1'b0;
    re_d    = 1'b0;
    rl_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bad) begin
          rv_d = 1'b1;
          re_d = 1'b1;
        end else if (good_wr) begin
          rv_d = 1'b1;
        end else if (good_rd) begin
          raw_d  = rd_word;
          lane_d = req_addr_i[1:0];
          size_d = req_size_i;
          uns_d  = req_unsigned_i;
          if (READ_LATENCY == 1) begin
            rv_d = 1'b1;
            rl_d = 1'b1;
          end else begin
            state_d = READ;
            cnt_d   = 2'd0;
          end
        end
      end
      READ: begin
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
          rv_d    = 1'b1;
          rl_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      raw_q   <= '0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      rv_q    <= 1'b0;
      re_q    <= 1'b0;
      rl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raw_q   <= raw_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rv_q    <= rv_d;
      re_q    <= re_d;
      rl_q    <= rl_d;
    end
  end

  always_comb begin
    lane_b = raw_q[{lane_q, 3'b000} +: 8];
    lane_h = lane_q[1] ? raw_q[31:16] : raw_q[15:0];
    ext    = '0;
    unique case (size_q)
      2'b00:   ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
      2'b01:   ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
      2'b10:   ext = raw_q;
      default: ext = '0;
    endcase
  end

  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q == READ);
  assign resp_valid_o = rv_q;
  assign resp_err_o   = re_q;
  assign resp_rdata_o = rl_q ? ext : '0;

`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;
  logic [31:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (good_rd) rd_cnt_q  <= rd_cnt_q + 32'd1;
      if (good_wr) wr_cnt_q  <= wr_cnt_q + 32'd1;
      if (bad)     err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign rd_count_o  = rd_cnt_q;
  assign wr_count_o  = wr_cnt_q;
  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: table-driven and scoreboard bench for dmem_ctrl,
// one instance at latency 1 and one at latency 3 with a nonzero base.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v1, v3;
  logic        wr, uns;
  logic [1:0]  sz;
  logic [31:0] addr, wd;

  logic        rdy1, rv1, re1, bsy1;
  logic [31:0] rd1;
  logic        rdy3, rv3, re3, bsy3;
  logic [31:0] rd3;
`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] rc1, wc1, ec1;
  logic [31:0] rc3, wc3, ec3;
`endif

  int checks = 0;
  int failures = 0;

  dmem_ctrl #(
    .ADDR_WIDTH(32),
    .DEPTH_WORDS(4096),
    .BASE_ADDR(32'h0),
    .READ_LATENCY(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(v1), .req_ready_o(rdy1),
    .req_write_i(wr), .req_size_i(sz),
    .req_unsigned_i(uns), .req_addr_i(addr),
    .req_wdata_i(wd), .resp_valid_o(rv1),
    .resp_rdata_o(rd1), .resp_err_o(re1),
    .busy_o(bsy1)
`ifdef DMEM_ACCESS_CNT_EN
    , .rd_count_o(rc1), .wr_count_o(wc1),
    .err_count_o(ec1)
`endif
  );

  dmem_ctrl #(
    .ADDR_WIDTH(32),
    .DEPTH_WORDS(16),
    .BASE_ADDR(32'h40),
    .READ_LATENCY(3)
  ) u3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(v3), .req_ready_o(rdy3),
    .req_write_i(wr), .req_size_i(sz),
    .req_unsigned_i(uns), .req_addr_i(addr),
    .req_wdata_i(wd), .resp_valid_o(rv3),
    .resp_rdata_o(rd3), .resp_err_o(re3),
    .busy_o(bsy3)
`ifdef DMEM_ACCESS_CNT_EN
    , .rd_count_o(rc3), .wr_count_o(wc3),
    .err_count_o(ec3)
`endif
  );

  typedef struct {
    logic        w;
    logic [1:0]  s;
    logic        u;
    logic [31:0] a;
    logic [31:0] d;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  logic [32:0] q1 [$];
  logic [32:0] q3 [$];
  logic [32:0] e1, e3;

  function automatic vec_t mk(logic w, logic [1:0] s,
                              logic u, logic [31:0] a,
                              logic [31:0] d, logic err,
                              logic [31:0] rd);
    vec_t v;
    v.w = w; v.s = s; v.u = u; v.a = a;
    v.d = d; v.err = err; v.rd = rd;
    return v;
  endfunction

  task automatic chk1(string n, logic got, logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0b want=%0b", n, got, want);
    end
  endtask

  task automatic chk32(string n, logic [31:0] got,
                       logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask

  // Response monitors: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rv1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL u1_unexpected_resp got err=%0b rdata=%h want none",
                 re1, rd1);
      end else begin
        e1 = q1.pop_front();
        if ({re1, rd1} !== e1) begin
          failures++;
          $display("FAIL u1_resp got err=%0b rdata=%h want err=%0b rdata=%h",
                   re1, rd1, e1[32], e1[31:0]);
        end
      end
    end
    if (rst_n && rv3) begin
      checks++;
      if (q3.size() == 0) begin
        failures++;
        $display("FAIL u3_unexpected_resp got err=%0b rdata=%h want none",
                 re3, rd3);
      end else begin
        e3 = q3.pop_front();
        if ({re3, rd3} !== e3) begin
          failures++;
          $display("FAIL u3_resp got err=%0b rdata=%h want err=%0b rdata=%h",
                   re3, rd3, e3[32], e3[31:0]);
        end
      end
    end
  end

  task automatic drive(logic w, logic [1:0] s, logic u,
                       logic [31:0] a, logic [31:0] d);
    wr = w; sz = s; uns = u; addr = a; wd = d;
  endtask

  task automatic req1(vec_t v);
    @(negedge clk);
    v1 = 1'b1;
    drive(v.w, v.s, v.u, v.a, v.d);
    q1.push_back({v.err, v.rd});
  endtask

  task automatic req3(logic w, logic [1:0] s, logic u,
                      logic [31:0] a, logic [31:0] d,
                      logic err, logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL u3_ready_timeout got ready=0 want ready=1");
    end
    v3 = 1'b1;
    drive(w, s, u, a, d);
    q3.push_back({err, rd});
    @(negedge clk);
    v3 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d want pending=0",
               q1.size() + q3.size());
    end
  endtask

  task automatic chk_reset_state();
    chk1("rst_ready1", rdy1, 1'b1);
    chk1("rst_valid1", rv1, 1'b0);
    chk1("rst_err1", re1, 1'b0);
    chk1("rst_busy1", bsy1, 1'b0);
    chk32("rst_rdata1", rd1, 32'h0);
    chk1("rst_ready3", rdy3, 1'b1);
    chk1("rst_valid3", rv3, 1'b0);
    chk1("rst_err3", re3, 1'b0);
    chk1("rst_busy3", bsy3, 1'b0);
    chk32("rst_rdata3", rd3, 32'h0);
  endtask

`ifdef DMEM_ACCESS_CNT_EN
  int m_rd, m_wr, m_err;
`endif

  initial begin
    rst_n = 1'b0;
    v1 = 1'b0;
    v3 = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

    tbl[0]  = mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0);
    tbl[1]  = mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF);
    tbl[2]  = mk(1, 2'b00, 0, 32'h13, 32'h7F, 0, 32'h0);
    tbl[3]  = mk(0, 2'b00, 0, 32'h13, 32'h0, 0, 32'h0000007F);
    tbl[4]  = mk(1, 2'b00, 0, 32'h12, 32'h80, 0, 32'h0);
    tbl[5]  = mk(0, 2'b00, 0, 32'h12, 32'h0, 0, 32'hFFFFFF80);
    tbl[6]  = mk(0, 2'b00, 1, 32'h12, 32'h0, 0, 32'h00000080);
    tbl[7]  = mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h7F80BEEF);
    tbl[8]  = mk(0, 2'b01, 0, 32'h11, 32'h0, 1, 32'h0);
    tbl[9]  = mk(1, 2'b10, 0, 32'h12, 32'h11111111, 1, 32'h0);
    tbl[10] = mk(0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0);
    tbl[11] = mk(0, 2'b10, 0, 32'h4000, 32'h0, 1, 32'h0);
    tbl[12] = mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h7F80BEEF);
    tbl[13] = mk(0, 2'b01, 0, 32'h10, 32'h0, 0, 32'hFFFFBEEF);
    tbl[14] = mk(0, 2'b01, 1, 32'h10, 32'h0, 0, 32'h0000BEEF);
    tbl[15] = mk(0, 2'b01, 0, 32'h12, 32'h0, 0, 32'h00007F80);
    tbl[16] = mk(1, 2'b01, 0, 32'h10, 32'hAAAA1234, 0, 32'h0);
    tbl[17] = mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h7F801234);
    tbl[18] = mk(1, 2'b00, 0, 32'h11, 32'hFFFFFF00, 0, 32'h0);
    tbl[19] = mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h7F800034);
    tbl[20] = mk(1, 2'b10, 0, 32'h3FFC, 32'h12345678, 0, 32'h0);
    tbl[21] = mk(0, 2'b10, 0, 32'h3FFC, 32'h0, 0, 32'h12345678);
    tbl[22] = mk(0, 2'b00, 0, 32'h3FFF, 32'h0, 0, 32'h00000012);
    tbl[23] = mk(0, 2'b01, 1, 32'h3FFE, 32'h0, 0, 32'h00001234);
    tbl[24] = mk(1, 2'b11, 0, 32'h20, 32'h0, 1, 32'h0);
    tbl[25] = mk(0, 2'b10, 0, 32'hFFFFFFFC, 32'h0, 1, 32'h0);

    #1;
    chk_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DMEM_ACCESS_CNT_EN
    m_rd = 0; m_wr = 0; m_err = 0;
`endif
    // Streamed back-to-back through the latency-1 instance.
    for (int i = 0; i < NV; i++) begin
      req1(tbl[i]);
`ifdef DMEM_ACCESS_CNT_EN
      if (tbl[i].err) m_err++;
      else if (tbl[i].w) m_wr++;
      else m_rd++;
`endif
    end
    @(negedge clk);
    v1 = 1'b0;
    drain();
`ifdef DMEM_ACCESS_CNT_EN
    chk32("cnt_tbl_rd", rc1, 32'(m_rd));
    chk32("cnt_tbl_wr", wc1, 32'(m_wr));
    chk32("cnt_tbl_err", ec1, 32'(m_err));
`endif

    // Latency-3 instance: base 0x40, 16 words, limit 0x80.
    req3(1, 2'b10, 0, 32'h50, 32'hCAFEF00D, 0, 32'h0);
    req3(0, 2'b10, 0, 32'h3C, 32'h0, 1, 32'h0);
    req3(0, 2'b10, 0, 32'h80, 32'h0, 1, 32'h0);
    req3(1, 2'b10, 0, 32'h7C, 32'h0BADCAFE, 0, 32'h0);
    req3(0, 2'b00, 0, 32'h7F, 32'h0, 0, 32'h0000000B);
    req3(0, 2'b01, 0, 32'h7C, 32'h0, 0, 32'hFFFFCAFE);
    drain();

    // Cycle-accurate timing of a latency-3 load.
    @(negedge clk);
    chk1("l3_ready_pre", rdy3, 1'b1);
    v3 = 1'b1;
    drive(0, 2'b10, 0, 32'h50, 32'h0);
    q3.push_back({1'b0, 32'hCAFEF00D});
    @(negedge clk);
    v3 = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      chk1($sformatf("l3_ready_c%0d", c), rdy3, 1'b0);
      chk1($sformatf("l3_busy_c%0d", c), bsy3, 1'b1);
      chk1($sformatf("l3_valid_c%0d", c), rv3, 1'b0);
      @(negedge clk);
    end
    chk1("l3_valid_c3", rv3, 1'b1);
    chk1("l3_ready_c3", rdy3, 1'b1);
    chk1("l3_busy_c3", bsy3, 1'b0);
    @(negedge clk);
    chk1("l3_valid_c4", rv3, 1'b0);
    drain();

    // Reset while a load is in READ: it must vanish.
    @(negedge clk);
    v3 = 1'b1;
    drive(0, 2'b10, 0, 32'h50, 32'h0);
    @(negedge clk);
    v3 = 1'b0;
    chk1("rst_mid_busy_pre", bsy3, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_state();
`ifdef DMEM_ACCESS_CNT_EN
    chk32("cnt_rst_rd", rc1, 32'h0);
    chk32("cnt_rst_wr", wc1, 32'h0);
    chk32("cnt_rst_err", ec1, 32'h0);
    chk32("cnt_rst_rd3", rc3, 32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk1("rst_mid_no_resp", rv3, 1'b0);
      chk1("rst_mid_ready", rdy3, 1'b1);
    end
    req3(0, 2'b10, 0, 32'h50, 32'h0, 0, 32'hCAFEF00D);
    req1(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h7F800034));
    @(negedge clk);
    v1 = 1'b0;
    drain();

`ifdef DMEM_ACCESS_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      req1(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h7F800034));
    for (int i = 0; i < 3; i++)
      req1(mk(1, 2'b00, 0, 32'h20 + 32'(i), 32'(i), 0, 32'h0));
    req1(mk(0, 2'b01, 0, 32'h21, 32'h0, 1, 32'h0));
    req1(mk(1, 2'b11, 0, 32'h20, 32'h0, 1, 32'h0));
    @(negedge clk);
    v1 = 1'b0;
    drain();
    chk32("cnt_rd5", rc1, 32'd5);
    chk32("cnt_wr3", wc1, 32'd3);
    chk32("cnt_err2", ec1, 32'd2);
    rst_n = 1'b0;
    #1;
    chk32("cnt_clr_rd", rc1, 32'h0);
    chk32("cnt_clr_wr", wc1, 32'h0);
    chk32("cnt_clr_err", ec1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
